// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one 12-bit binary-to-BCD converter among N_CH
// counter channels, with a per-channel result bank and valid flags.

module bcd_conv_sched_ch (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [11:0] value_i,
    input  logic        wr_i,
    input  logic [11:0] wr_val_i,
    input  logic [15:0] wr_bcd_i,
    output logic [15:0] bcd_o,
    output logic        valid_o,
    output logic        pending_o
);
    logic [11:0] done_val_q, done_val_d;
    logic [15:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;

    // A write records the value that was actually converted, so a value that
    // moved during the conversion still shows as pending afterwards.
    always_comb begin
        done_val_d = done_val_q;
        bcd_d      = bcd_q;
        valid_d    = valid_q & en_i;
        if (wr_i) begin
            done_val_d = wr_val_i;
            bcd_d      = wr_bcd_i;
            valid_d    = en_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_val_q <= '0;
            bcd_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            done_val_q <= done_val_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
        end
    end

    assign bcd_o     = bcd_q;
    assign valid_o   = valid_q;
    assign pending_o = en_i & (~valid_q | (value_i != done_val_q));
endmodule

module bcd_conv_sched #(
    parameter int N_CH    = 4,
    parameter int CW      = $clog2(N_CH),
    parameter int LOW_TMO = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH*12-1:0]   ch_value_i,
    input  logic [N_CH-1:0]      ch_en_i,
    output logic [11:0]          conv_value_o,
    input  logic [15:0]          conv_bcd_i,
    input  logic                 conv_rdy_i,
    output logic [N_CH*16-1:0]   ch_bcd_o,
    output logic [N_CH-1:0]      ch_valid_o,
    output logic                 busy_o,
    output logic [CW-1:0]        cur_ch_o,
    output logic                 err_o
);
    localparam int TW = (LOW_TMO > 1) ? $clog2(LOW_TMO) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_LOW  = 2'd1;
    localparam logic [1:0] S_WAIT_HIGH = 2'd2;
    localparam logic [1:0] S_WRITE     = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] g_q, g_d;
    logic [CW-1:0] rr_ptr_q, rr_ptr_d;
    logic [11:0]   lat_val_q, lat_val_d;
    logic [11:0]   conv_value_q, conv_value_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] wr_en;
    logic [11:0]     val_a [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign val_a[i] = ch_value_i[12*i +: 12];
        assign wr_en[i] = (state_q == S_WRITE) && (g_q == CW'(i));

        bcd_conv_sched_ch u_ch (
            .clk       (clk),
            .reset     (reset),
            .en_i      (ch_en_i[i]),
            .value_i   (ch_value_i[12*i +: 12]),
            .wr_i      (wr_en[i]),
            .wr_val_i  (lat_val_q),
            .wr_bcd_i  (conv_bcd_i),
            .bcd_o     (ch_bcd_o[16*i +: 16]),
            .valid_o   (ch_valid_o[i]),
            .pending_o (pending[i])
        );
    end

    // Round-robin search from rr_ptr, wrapping modulo N_CH.
    logic          gnt_found;
    logic [CW-1:0] gnt;
    int            idx;

    always_comb begin
        gnt_found = 1'b0;
        gnt       = rr_ptr_q;
        idx       = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_CH;
            if (!gnt_found && pending[idx]) begin
                gnt_found = 1'b1;
                gnt       = CW'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        rr_ptr_d     = rr_ptr_q;
        lat_val_d    = lat_val_q;
        conv_value_d = conv_value_q;
        tmo_cnt_d    = tmo_cnt_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    g_d       = gnt;
                    lat_val_d = val_a[gnt];
                    // Converter already holds this value's result: skip reissue.
                    if (val_a[gnt] == conv_value_q) begin
                        state_d = S_WRITE;
                    end else begin
                        conv_value_d = val_a[gnt];
                        tmo_cnt_d    = '0;
                        state_d      = S_WAIT_LOW;
                    end
                end
            end
            S_WAIT_LOW: begin
                if (!conv_rdy_i) begin
                    state_d = S_WAIT_HIGH;
                end else if (tmo_cnt_q == TW'(LOW_TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (conv_rdy_i) state_d = S_WRITE;
            end
            S_WRITE: begin
                rr_ptr_d = (int'(g_q) == N_CH - 1) ? '0 : g_q + CW'(1);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            g_q          <= '0;
            rr_ptr_q     <= '0;
            lat_val_q    <= '0;
            conv_value_q <= '0;
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            rr_ptr_q     <= rr_ptr_d;
            lat_val_q    <= lat_val_d;
            conv_value_q <= conv_value_d;
            tmo_cnt_q    <= tmo_cnt_d;
            err_q        <= err_d;
        end
    end

    assign conv_value_o = conv_value_q;
    assign busy_o       = (state_q != S_IDLE);
    assign cur_ch_o     = g_q;
    assign err_o        = err_q;
endmodule
